// File: rtl/zx_mem_pkg.sv
// Shared types and sizes for the Z80-side memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, bank/address/data widths, default ROM bank
// count and width of the read-stretch counter.
package zx_mem_pkg;

    localparam int NUM_BANKS     = 8;
    localparam int BANK_W        = 3;
    localparam int AD_W          = 13;
    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 16;
    localparam int ROM_BANKS_DEF = 2;
    localparam int WAIT_CNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        RD_WAIT = 3'd3,
        WR      = 3'd4,
        HOLD    = 3'd5
    } state_t;

endpackage

// File: rtl/zx_mem_ctrl_if.sv
// Z80 CPU bus bundle seen by the memory controller.
// Latency: n/a (wiring only).
// Backpressure: cpu_wait_n low stretches the CPU cycle.
//
// Ports (master = CPU side, slave = controller side):
//   cpu_mreq_n, cpu_rd_n, cpu_wr_n : active-low strobes from the CPU
//   cpu_addr[15:0], cpu_dout[7:0]  : address and write data from the CPU
//   cpu_din[7:0], cpu_wait_n       : registered read data and WAIT to the CPU
interface zx_mem_ctrl_if;
    import zx_mem_pkg::*;

    logic                cpu_mreq_n;
    logic                cpu_rd_n;
    logic                cpu_wr_n;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_dout;
    logic [DATA_W-1:0]   cpu_din;
    logic                cpu_wait_n;

    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        input  cpu_din, cpu_wait_n
    );

    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        output cpu_din, cpu_wait_n
    );

endinterface

// File: rtl/zx_mem_bank_dec.sv
// Decodes the latched bank number into a one-hot chip enable and a ROM flag.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_bank (latched bank), i_en (access enable), o_ce (one-hot enable,
// all zero when i_en is low), o_is_rom (bank below ROM_BANKS).
module zx_mem_bank_dec
    import zx_mem_pkg::*;
#(
    parameter int ROM_BANKS = ROM_BANKS_DEF
) (
    input  logic [BANK_W-1:0]    i_bank,
    input  logic                 i_en,
    output logic [NUM_BANKS-1:0] o_ce,
    output logic                 o_is_rom
);

    always_comb begin
        o_ce = '0;
        if (i_en) begin
            o_ce[i_bank] = 1'b1;
        end
    end

    assign o_is_rom = (int'(i_bank) < ROM_BANKS);

endmodule

// File: rtl/zx_mem_ctrl.sv
// Converts Z80 MREQ/RD/WR cycles into single-port 8 KB bank accesses.
// Latency: read 2+WAIT_CYCLES cycles with WAIT low, write 1 cycle with WAIT low.
// Backpressure: cpu_wait_n stretches the CPU; HOLD waits for mreq_n release.
//
// Ports: clk, reset (sync, active-high), cpu (zx_mem_ctrl_if.slave),
// mem_ce[7:0] one-hot bank enable, mem_oce/mem_wre shared enables,
// mem_ad[12:0] bank-local address, mem_data[7:0] shared tri-state bus,
// wp_violation (sticky ROM-write flag, present only when ROM_WP_EN is defined).
// Build option: define ROM_WP_EN to block writes to banks below ROM_BANKS.
module zx_mem_ctrl
    import zx_mem_pkg::*;
#(
    parameter int ROM_BANKS   = ROM_BANKS_DEF,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    zx_mem_ctrl_if.slave         cpu,
    output logic [NUM_BANKS-1:0] mem_ce,
    output logic                 mem_oce,
    output logic                 mem_wre,
    output logic [AD_W-1:0]      mem_ad,
    inout  wire  [DATA_W-1:0]    mem_data
`ifdef ROM_WP_EN
    ,
    output logic                 wp_violation
`endif
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_armed;
    logic [BANK_W-1:0]     r_bank;
    logic [AD_W-1:0]       r_ad;
    logic [DATA_W-1:0]     r_wdat;
    logic [DATA_W-1:0]     r_din;
    logic [WAIT_CNT_W-1:0] r_wcnt;

    logic w_accept;
    logic w_is_read;
    logic w_rd_phase;
    logic w_wr_phase;
    logic w_is_rom;
    logic w_blocked;
    logic w_bank_en;

    // Only a request seen after a fresh mreq_n-high IDLE cycle is taken,
    // so an access still asserted across reset is never replayed.
    assign w_accept  = r_armed && !cpu.cpu_mreq_n && (!cpu.cpu_rd_n || !cpu.cpu_wr_n);
    assign w_is_read = !cpu.cpu_rd_n;   // read wins if both strobes are low

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_is_read ? RD_ADDR : WR;
                end
            end
            RD_ADDR: w_next = RD_DATA;
            RD_DATA: w_next = (WAIT_CYCLES > 0) ? RD_WAIT : HOLD;
            RD_WAIT: begin
                if (r_wcnt == WAIT_CNT_W'(WAIT_CYCLES - 1)) begin
                    w_next = HOLD;
                end
            end
            WR:      w_next = HOLD;
            HOLD: begin
                if (cpu.cpu_mreq_n) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers: address/bank/write-data latch, read capture, stretch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_bank  <= '0;
            r_ad    <= '0;
            r_wdat  <= '0;
            r_din   <= '0;
            r_wcnt  <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_armed <= 1'b0;
                    r_bank  <= cpu.cpu_addr[ADDR_W-1:AD_W];
                    r_ad    <= cpu.cpu_addr[AD_W-1:0];
                    if (!w_is_read) begin
                        r_wdat <= cpu.cpu_dout;
                    end
                end else if (cpu.cpu_mreq_n) begin
                    r_armed <= 1'b1;
                end
            end
            if (r_state == RD_DATA) begin
                r_din <= mem_data;
            end
            if (r_state == RD_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end else begin
                r_wcnt <= '0;
            end
        end
    end

`ifdef ROM_WP_EN
    logic r_wp;

    assign w_blocked = w_is_rom;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= 1'b0;
        end else if (r_state == WR && w_is_rom) begin
            r_wp <= 1'b1;
        end
    end

    assign wp_violation = r_wp;
`else
    // ROM banks are writable (runtime ROM image loading); the ROM flag is ignored.
    assign w_blocked = w_is_rom & 1'b0;
`endif

    // All memory-side strobes decode from the state register only.
    assign w_rd_phase = (r_state == RD_ADDR) || (r_state == RD_DATA);
    assign w_wr_phase = (r_state == WR) && !w_blocked;
    assign w_bank_en  = w_rd_phase || w_wr_phase;

    zx_mem_bank_dec #(
        .ROM_BANKS (ROM_BANKS)
    ) u_bank_dec (
        .i_bank   (r_bank),
        .i_en     (w_bank_en),
        .o_ce     (mem_ce),
        .o_is_rom (w_is_rom)
    );

    assign mem_oce  = w_rd_phase;
    assign mem_wre  = w_wr_phase;
    assign mem_ad   = r_ad;
    assign mem_data = w_wr_phase ? r_wdat : {DATA_W{1'bz}};

    assign cpu.cpu_din    = r_din;
    assign cpu.cpu_wait_n = !((r_state == RD_ADDR) || (r_state == RD_DATA) ||
                              (r_state == RD_WAIT) || (r_state == WR));

endmodule

// File: tb/tb_zx_mem_ctrl.sv
// Bench for zx_mem_ctrl: two instances (WAIT_CYCLES 0 and 3), each with its
// own registered-read memory model; expected access results are queued at
// stimulus time and checked when the access completes.
module tb_zx_mem_ctrl;
    import zx_mem_pkg::*;

    localparam int W1 = 3;
    localparam int RB = 2;
`ifdef ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    zx_mem_ctrl_if bus0 ();
    zx_mem_ctrl_if bus1 ();

    logic [7:0]  ce0, ce1;
    logic        oce0, oce1, wre0, wre1;
    logic [12:0] ad0, ad1;
    wire  [7:0]  md0, md1;
`ifdef ROM_WP_EN
    logic        wp0, wp1;
`endif

    zx_mem_ctrl #(.ROM_BANKS(RB), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .cpu(bus0),
        .mem_ce(ce0), .mem_oce(oce0), .mem_wre(wre0), .mem_ad(ad0), .mem_data(md0)
`ifdef ROM_WP_EN
        , .wp_violation(wp0)
`endif
    );

    zx_mem_ctrl #(.ROM_BANKS(RB), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .cpu(bus1),
        .mem_ce(ce1), .mem_oce(oce1), .mem_wre(wre1), .mem_ad(ad1), .mem_data(md1)
`ifdef ROM_WP_EN
        , .wp_violation(wp1)
`endif
    );

    // Memory model: registers mem[ad] while ce&oce, drives the bus while ce&oce.
    logic [7:0] m0 [65536];
    logic [7:0] m1 [65536];
    logic [7:0] q0, q1;

    function automatic logic [2:0] oh2b(input logic [7:0] ce);
        logic [2:0] b;
        b = 3'd0;
        for (int i = 0; i < 8; i++) if (ce[i]) b = 3'(i);
        return b;
    endfunction

    always @(posedge clk) begin
        if (|ce0 && oce0) q0 <= m0[{oh2b(ce0), ad0}];
        if (|ce0 && wre0) m0[{oh2b(ce0), ad0}] <= md0;
        if (|ce1 && oce1) q1 <= m1[{oh2b(ce1), ad1}];
        if (|ce1 && wre1) m1[{oh2b(ce1), ad1}] <= md1;
    end

    assign md0 = (|ce0 && oce0) ? q0 : 8'bz;
    assign md1 = (|ce1 && oce1) ? q1 : 8'bz;

    // Reference contents, updated by the bench when it issues a write.
    logic [7:0] sh [2][65536];

    typedef struct {
        bit         rd;
        logic [7:0] din;
        logic [7:0] ce;
        logic [12:0] ad;
        int         wlo;
        int         ce_cyc;
        int         wre_cyc;
    } exp_t;
    exp_t sbq [$];

    task automatic preload(input int k, input logic [15:0] a, input logic [7:0] d);
        if (k == 0) m0[a] = d; else m1[a] = d;
        sh[k][a] = d;
    endtask

    task automatic drive(input int k, input logic mreq_n, input logic rd_n, input logic wr_n,
                         input logic [15:0] a, input logic [7:0] d);
        if (k == 0) begin
            bus0.cpu_mreq_n = mreq_n; bus0.cpu_rd_n = rd_n; bus0.cpu_wr_n = wr_n;
            bus0.cpu_addr = a; bus0.cpu_dout = d;
        end else begin
            bus1.cpu_mreq_n = mreq_n; bus1.cpu_rd_n = rd_n; bus1.cpu_wr_n = wr_n;
            bus1.cpu_addr = a; bus1.cpu_dout = d;
        end
    endtask

    task automatic sample(input int k, output logic wn, output logic [7:0] ce, output logic oce,
                          output logic wre, output logic [12:0] ad, output logic [7:0] din);
        if (k == 0) begin
            wn = bus0.cpu_wait_n; ce = ce0; oce = oce0; wre = wre0; ad = ad0; din = bus0.cpu_din;
        end else begin
            wn = bus1.cpu_wait_n; ce = ce1; oce = oce1; wre = wre1; ad = ad1; din = bus1.cpu_din;
        end
    endtask

    task automatic idle2(input int k);
        drive(k, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        repeat (2) begin @(posedge clk); @(negedge clk); end
    endtask

    // One complete access; called and returning at a negedge.
    task automatic access(input int k, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [7:0] d);
        exp_t e, g;
        bit blk, done;
        int n, wlo, cec, wrec, adbad, w;
        logic wn, oce, wre;
        logic [7:0] ce, ceor, din;
        logic [12:0] ad;
        w   = (k == 0) ? 0 : W1;
        blk = WP && (int'(a[15:13]) < RB);
        e.rd      = rd;
        e.din     = sh[k][a];
        e.ce      = (rd || !blk) ? (8'h01 << a[15:13]) : 8'h00;
        e.ad      = a[12:0];
        e.wlo     = rd ? 2 + w : 1;
        e.ce_cyc  = rd ? 2 : (blk ? 0 : 1);
        e.wre_cyc = (!rd && !blk) ? 1 : 0;
        if (!rd && !blk) sh[k][a] = d;
        sbq.push_back(e);

        drive(k, 1'b0, !rd, !wr, a, d);
        n = 0; wlo = 0; cec = 0; wrec = 0; adbad = 0; ceor = 8'h00; done = 1'b0; din = 8'h00;
        while (!done && n < 25) begin
            @(posedge clk); @(negedge clk);
            sample(k, wn, ce, oce, wre, ad, din);
            n++;
            if (!wn) wlo++;
            if (ce != 8'h00) begin
                cec++;
                ceor |= ce;
                if (ad !== e.ad) adbad++;
            end
            if (wre) wrec++;
            if (wn && wlo > 0) done = 1'b1;
        end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $error("FAIL access_done observed=%0h expected=1", done); end
        g = sbq.pop_front();
        vectors++;
        if (wlo !== g.wlo) begin miscompares++; $error("FAIL wait_low_cycles observed=%0d expected=%0d", wlo, g.wlo); end
        vectors++;
        if (ceor !== g.ce) begin miscompares++; $error("FAIL mem_ce observed=%0h expected=%0h", ceor, g.ce); end
        vectors++;
        if (cec !== g.ce_cyc) begin miscompares++; $error("FAIL ce_cycles observed=%0d expected=%0d", cec, g.ce_cyc); end
        vectors++;
        if (wrec !== g.wre_cyc) begin miscompares++; $error("FAIL wre_cycles observed=%0d expected=%0d", wrec, g.wre_cyc); end
        vectors++;
        if (adbad !== 0) begin miscompares++; $error("FAIL mem_ad_mismatches observed=%0d expected=0", adbad); end
        if (g.rd) begin
            vectors++;
            if (din !== g.din) begin miscompares++; $error("FAIL cpu_din observed=%0h expected=%0h", din, g.din); end
        end
        idle2(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic wn, oce, wre;
        logic [7:0] ce, din, ceor;
        logic [12:0] ad;
        bit saw_wait;

        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        drive(1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        preload(0, 16'h0000, 8'hF3);
        preload(1, 16'h0000, 8'hF3);
        preload(1, 16'hFFFF, 8'h5E);
        preload(1, 16'h2000, 8'h11);
        preload(0, 16'h8000, 8'h3C);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sample(k, wn, ce, oce, wre, ad, din);
            vectors++;
            if (wn !== 1'b1) begin miscompares++; $error("FAIL rst_wait_n observed=%0h", wn); end
            vectors++;
            if (ce !== 8'h00) begin miscompares++; $error("FAIL rst_ce observed=%0h", ce); end
            vectors++;
            if (oce !== 1'b0) begin miscompares++; $error("FAIL rst_oce observed=%0h", oce); end
            vectors++;
            if (wre !== 1'b0) begin miscompares++; $error("FAIL rst_wre observed=%0h", wre); end
            vectors++;
            if (ad !== 13'h0000) begin miscompares++; $error("FAIL rst_ad observed=%0h", ad); end
            vectors++;
            if (din !== 8'h00) begin miscompares++; $error("FAIL rst_din observed=%0h", din); end
        end
`ifdef ROM_WP_EN
        vectors++;
        if (wp1 !== 1'b0) begin miscompares++; $error("FAIL rst_wp observed=%0h", wp1); end
`endif
        reset = 1'b0;
        @(posedge clk); @(negedge clk);

        // Basic ROM read, write/readback in RAM bank 2.
        access(0, 1'b1, 1'b0, 16'h0000, 8'h00);
        access(0, 1'b0, 1'b1, 16'h5C3A, 8'hA5);
        access(0, 1'b1, 1'b0, 16'h5C3A, 8'h00);

        // Stretched read of the top address.
        access(1, 1'b1, 1'b0, 16'hFFFF, 8'h00);

        // ROM writes: blocked with write protection, applied otherwise.
        access(1, 1'b0, 1'b1, 16'h2000, 8'h77);
`ifdef ROM_WP_EN
        vectors++;
        if (wp1 !== 1'b1) begin miscompares++; $error("FAIL wp_set observed=%0h", wp1); end
`endif
        access(1, 1'b1, 1'b0, 16'h2000, 8'h00);
        access(1, 1'b0, 1'b1, 16'h0000, 8'h00);
        access(1, 1'b1, 1'b0, 16'h0000, 8'h00);
`ifdef ROM_WP_EN
        vectors++;
        if (wp1 !== 1'b1) begin miscompares++; $error("FAIL wp_sticky observed=%0h", wp1); end
`endif

        // Both strobes low: read wins, memory contents untouched.
        access(0, 1'b1, 1'b1, 16'h8000, 8'h99);
        vectors++;
        if (m0[16'h8000] !== 8'h3C) begin miscompares++; $error("FAIL dual_mem_untouched observed=%0h", m0[16'h8000]); end

        // Reset during RD_DATA with the request held.
        drive(0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        sample(0, wn, ce, oce, wre, ad, din);
        vectors++;
        if (oce !== 1'b1) begin miscompares++; $error("FAIL mid_in_rd_data_oce observed=%0h", oce); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        sample(0, wn, ce, oce, wre, ad, din);
        vectors++;
        if (wn !== 1'b1) begin miscompares++; $error("FAIL mid_rst_wait_n observed=%0h", wn); end
        vectors++;
        if (ce !== 8'h00) begin miscompares++; $error("FAIL mid_rst_ce observed=%0h", ce); end
        vectors++;
        if (oce !== 1'b0) begin miscompares++; $error("FAIL mid_rst_oce observed=%0h", oce); end
        vectors++;
        if (ad !== 13'h0000) begin miscompares++; $error("FAIL mid_rst_ad observed=%0h", ad); end
        vectors++;
        if (din !== 8'h00) begin miscompares++; $error("FAIL mid_rst_din observed=%0h", din); end
`ifdef ROM_WP_EN
        vectors++;
        if (wp1 !== 1'b0) begin miscompares++; $error("FAIL mid_rst_wp observed=%0h", wp1); end
`endif
        reset = 1'b0;
        ceor = 8'h00; saw_wait = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            sample(0, wn, ce, oce, wre, ad, din);
            ceor |= ce;
            if (!wn) saw_wait = 1'b1;
        end
        vectors++;
        if (ceor !== 8'h00) begin miscompares++; $error("FAIL no_replay_ce observed=%0h", ceor); end
        vectors++;
        if (saw_wait !== 1'b0) begin miscompares++; $error("FAIL no_replay_wait observed=%0h", saw_wait); end
        idle2(0);
        access(0, 1'b1, 1'b0, 16'h5C3A, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zx_mem_ctrl.md
# zx_mem_ctrl

Z80-side memory access controller for the ZX Spectrum core. Converts CPU bus cycles (MREQ/RD/WR, 16-bit address) into the synchronous single-port memory protocol used by the 8 KB ROM/RAM blocks: per-bank chip enable, output enable, write enable, 13-bit address and a shared tri-state data bus. It sits directly upstream of the memory banks. It stretches CPU cycles with WAIT to cover the memory's one-cycle registered read latency.

## Interface
- `ROM_BANKS`, default 2: banks 0..ROM_BANKS-1 are ROM (0x0000–0x3FFF by default).
- `WAIT_CYCLES`, default 0: extra read-stretch cycles after data capture, range 0..7.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `cpu_mreq_n` in 1: memory request, active-low, synchronous to clk.
- `cpu_rd_n` in 1: read strobe, active-low.
- `cpu_wr_n` in 1: write strobe, active-low.
- `cpu_addr` in 16: CPU address.
- `cpu_dout` in 8: write data from CPU.
- `cpu_din` out 8: registered read data to CPU.
- `cpu_wait_n` out 1: WAIT to CPU, active-low.
- `mem_ce` out 8: one-hot bank enable, bank = cpu_addr[15:13].
- `mem_oce` out 1: memory output enable, shared.
- `mem_wre` out 1: memory write enable, shared.
- `mem_ad` out 13: bank-local address, cpu_addr[12:0] latched.
- `mem_data` inout 8: shared tri-state bus. Driven only in WR, otherwise Z.
- `wp_violation` out 1: sticky flag for a ROM write attempt. Exists only with ROM_WP_EN.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, RD_WAIT, WR, HOLD.
- `armed` flag is cleared by reset and set when cpu_mreq_n is sampled high in IDLE. A request is accepted only when armed=1, so an access left asserted across reset is never replayed.
- IDLE: all enables are 0 and cpu_wait_n=1. On request with mreq_n=0 and rd_n=0: latch address and bank, then go to RD_ADDR. On mreq_n=0, wr_n=0, rd_n=1: latch address, bank and cpu_dout, then go to WR. If rd_n and wr_n are both low, the read wins.
- RD_ADDR: mem_ce[bank]=1, mem_oce=1, mem_wre=0. The memory registers mem[ad] at the end of this cycle. Next state is RD_DATA.
- RD_DATA: same enables, so the memory drives mem_data. cpu_din is captured from mem_data at the end of the cycle. Next state is RD_WAIT if WAIT_CYCLES>0, else HOLD.
- RD_WAIT: enables are 0. A 3-bit counter runs WAIT_CYCLES cycles, then the FSM goes to HOLD.
- WR: mem_ce[bank]=1, mem_wre=1, mem_oce=0, mem_data=latched write data, for exactly one cycle. Next state is HOLD.
- HOLD: enables are 0 and cpu_wait_n=1. cpu_din is held. The FSM stays until mreq_n=1, then returns to IDLE.
- cpu_wait_n=0 in RD_ADDR, RD_DATA, RD_WAIT and WR. It is 1 in IDLE and HOLD.
- An early mreq_n deassertion mid-cycle does not abort the access. The access completes, and HOLD exits on the next cycle.
- Address 0xFFFF maps to bank 7 with mem_ad=0x1FFF. There is no wrap or carry logic.
- All enable and bus outputs are decoded from the state register, so they are glitch-free Moore outputs.

## Timing
- Reset values: state=IDLE, armed=0, cpu_din=0x00, cpu_wait_n=1, mem_ce=0, mem_oce=0, mem_wre=0, mem_ad=0, mem_data=Z, wp_violation=0.
- A reset mid-access forces the reset values on the next edge. Any write in flight is dropped if reset coincides with WR.
- Read, with the request sampled at edge 0: RD_ADDR in cycle 1, RD_DATA in cycle 2, cpu_din valid from edge 3 + WAIT_CYCLES, HOLD from the same edge. WAIT is low for 2+WAIT_CYCLES cycles.
- Write: WR in cycle 1 with the memory write at edge 2, then HOLD. WAIT is low for 1 cycle.
- Back-to-back accesses: minimum of one IDLE cycle with mreq_n high between accesses.

## Configuration
- `ROM_WP_EN` defined:
  - A write whose bank < ROM_BANKS still goes through WR and HOLD timing, but mem_wre and mem_ce stay 0 and mem_data stays Z.
  - wp_violation is set and held until reset.
- `ROM_WP_EN` undefined: ROM banks are writable like RAM, which is used for loading ROM images at runtime. The wp_violation port is absent.

## Structure
- Package `zx_mem_pkg`: state enum, NUM_BANKS=8, BANK_W=3, AD_W=13, default ROM_BANKS, WAIT counter width.
- Sub-module `zx_mem_bank_dec`: combinational decode of the latched bank into one-hot mem_ce, gated by an enable, plus the is_rom flag.

## Test plan
- Reset with memory bank 0 preloaded with 0xF3 at 0x0000, then read 0x0000: ce=0x01 for 2 cycles, cpu_din=0xF3, WAIT low exactly 2 cycles.
- Write 0xA5 to 0x5C3A, then read 0x5C3A: ce=0x04, wre for 1 cycle, mem_ad=0x1C3A, readback 0xA5.
- WAIT_CYCLES=3, read 0xFFFF: ce=0x80, mem_ad=0x1FFF, WAIT low 5 cycles.
- With ROM_WP_EN, write 0x00 to 0x0000: mem_wre never 1, wp_violation=1, a following read still returns 0xF3.
- Reset asserted during RD_DATA with mreq_n held low: outputs at reset values next cycle, no new access until mreq_n goes high then low.
- rd_n and wr_n low together at 0x8000: read performed, mem_wre stays 0, mem_data never driven by the controller.
